// File: rtl/sp_arb_pkg.sv
// Shared types for the sp_ff_arbiter block.
//   arb_state_t : sequencer state (normal arbitration or flush sweep)
//   port_id_t   : identifies a request port; also used as the round-robin pointer
package sp_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

endpackage

// File: rtl/sp_ff_arbiter.sv
// Two-port round-robin arbiter and flush sequencer for one sp_ff_array.
//
// Ports:
//   clk0, rst0_n                    clock, asynchronous active-low reset
//   a_* / b_*                       request ports (valid/ready handshake, we, addr, wdata)
//   a_rvalid / b_rvalid, rdata      one-cycle read response, rdata shared by both ports
//   flush_req / flush_busy / flush_done
//                                   flush sweep control and status
//   csb0, web0, addr0, din0, dout0  array pins (csb0/web0 active-low)
//
// One access per cycle goes to the array. Grant and array drive are
// combinational; the read response appears one cycle after the grant.
// A flush writes FLUSH_VALUE to every set while both requesters are stalled.
module sp_ff_arbiter
    import sp_arb_pkg::*;
#(
    parameter int               S_INDEX     = 4,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic               clk0,
    input  logic               rst0_n,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic               a_we,
    input  logic [S_INDEX-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    output logic               a_rvalid,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic               b_we,
    input  logic [S_INDEX-1:0] b_addr,
    input  logic [WIDTH-1:0]   b_wdata,
    output logic               b_rvalid,
    output logic [WIDTH-1:0]   rdata,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    output logic               csb0,
    output logic               web0,
    output logic [S_INDEX-1:0] addr0,
    output logic [WIDTH-1:0]   din0,
    input  logic [WIDTH-1:0]   dout0
);

    localparam logic [S_INDEX-1:0] LAST_SET = {S_INDEX{1'b1}};
    localparam logic [S_INDEX-1:0] CNT_ONE  = S_INDEX'(1);

    arb_state_t         state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;
    port_id_t           prio_q, prio_d;
    logic               a_rvalid_q, a_rvalid_d;
    logic               b_rvalid_q, b_rvalid_d;
    logic               done_q, done_d;
    logic               a_grant, b_grant;

    // Next-state, grant selection and array pin drive.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        done_d     = 1'b0;
        a_grant    = 1'b0;
        b_grant    = 1'b0;
        csb0       = 1'b1;
        web0       = 1'b1;
        addr0      = '0;
        din0       = '0;

        case (state_q)
            IDLE: begin
                // rst0_n in the grant term keeps both readies low
                // (and the array deselected) for the whole reset pulse.
                if (!rst0_n) begin
                    a_grant = 1'b0;
                    b_grant = 1'b0;
                end else if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (a_valid && (!b_valid || prio_q == PORT_A)) begin
                    a_grant = 1'b1;
                end else if (b_valid) begin
                    b_grant = 1'b1;
                end else begin
                    a_grant = 1'b0;
                    b_grant = 1'b0;
                end
            end
            FLUSH: begin
                csb0  = 1'b0;
                web0  = 1'b0;
                addr0 = cnt_q;
                din0  = FLUSH_VALUE;
                // Stop on the last set rather than wrapping the counter.
                if (cnt_q == LAST_SET) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (a_grant) begin
            csb0   = 1'b0;
            web0   = ~a_we;
            addr0  = a_addr;
            din0   = a_wdata;
            prio_d = PORT_B;
        end else if (b_grant) begin
            csb0   = 1'b0;
            web0   = ~b_we;
            addr0  = b_addr;
            din0   = b_wdata;
            prio_d = PORT_A;
        end else begin
            prio_d = prio_q;
        end

        a_rvalid_d = a_grant & ~a_we;
        b_rvalid_d = b_grant & ~b_we;
    end

    // State, flush counter, round-robin pointer and response flags.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prio_q     <= PORT_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            done_q     <= done_d;
        end
    end

    assign a_ready    = a_grant;
    assign b_ready    = b_grant;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign flush_busy = (state_q != IDLE);
    assign flush_done = done_q;
    // Array output is only meaningful in the response cycle; hold 0 otherwise.
    assign rdata      = (a_rvalid_q | b_rvalid_q) ? dout0 : '0;

endmodule

// File: tb/tb_sp_ff_arbiter.sv
// Self-checking bench for sp_ff_arbiter with a behavioural single-port array.
module tb_sp_ff_arbiter;

    logic       clk0;
    logic       rst0_n;
    logic       a_valid, a_ready, a_we, a_rvalid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_valid, b_ready, b_we, b_rvalid;
    logic [3:0] b_addr;
    logic [7:0] b_wdata;
    logic [7:0] rdata;
    logic       flush_req, flush_busy, flush_done;
    logic       csb0, web0;
    logic [3:0] addr0;
    logic [7:0] din0, dout0;

    int n_checks = 0;
    int n_errors = 0;

    sp_ff_arbiter #(.S_INDEX(4), .WIDTH(8), .FLUSH_VALUE(8'h5A)) dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Array model: pins latched at the edge, operation performed over the next cycle.
    logic [7:0] mem [16];
    logic       lat_csb, lat_web;
    logic [3:0] lat_addr;
    logic [7:0] lat_din;

    always @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            lat_csb  <= 1'b1;
            lat_web  <= 1'b1;
            lat_addr <= 4'd0;
            lat_din  <= 8'h00;
        end else begin
            if (!lat_csb && !lat_web) mem[lat_addr] <= lat_din;
            lat_csb  <= csb0;
            lat_web  <= web0;
            lat_addr <= addr0;
            lat_din  <= din0;
        end
    end
    assign dout0 = mem[lat_addr];

    typedef struct {
        logic       av, awe; logic [3:0] aaddr; logic [7:0] awd;
        logic       bv, bwe; logic [3:0] baddr; logic [7:0] bwd;
        logic       ar, br, csb, web; logic [3:0] addr; logic [7:0] din;
        logic       arv, brv;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic drive(input logic av, input logic awe, input logic [3:0] aad, input logic [7:0] awd,
                         input logic bv, input logic bwe, input logic [3:0] bad, input logic [7:0] bwd);
        a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    endtask

    task automatic chk_idle_pins(input string nm);
        chk({nm, " csb0"}, csb0, 1'b1);
        chk({nm, " web0"}, web0, 1'b1);
        chk({nm, " addr0"}, addr0, 4'd0);
        chk({nm, " din0"}, din0, 8'h00);
    endtask

    initial begin
        bit seen;
        tbl[0] = '{1'b1,1'b1,4'd3,8'h11, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'd3,8'h11, 1'b0,1'b0};
        tbl[1] = '{1'b1,1'b0,4'd5,8'h00, 1'b1,1'b0,4'd9,8'h00, 1'b0,1'b1,1'b0,1'b1,4'd9,8'h00, 1'b0,1'b0};
        tbl[2] = '{1'b1,1'b0,4'd5,8'h00, 1'b1,1'b0,4'd9,8'h00, 1'b1,1'b0,1'b0,1'b1,4'd5,8'h00, 1'b0,1'b1};
        tbl[3] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,1'b1,1'b1,4'd0,8'h00, 1'b1,1'b0};
        tbl[4] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,4'd7,8'h77, 1'b0,1'b1,1'b0,1'b0,4'd7,8'h77, 1'b0,1'b0};
        tbl[5] = '{1'b1,1'b1,4'd2,8'h22, 1'b1,1'b0,4'd9,8'h00, 1'b1,1'b0,1'b0,1'b0,4'd2,8'h22, 1'b0,1'b0};
        tbl[6] = '{1'b1,1'b0,4'd3,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,1'b1,4'd3,8'h00, 1'b0,1'b0};
        tbl[7] = '{1'b1,1'b0,4'd5,8'h00, 1'b1,1'b0,4'd9,8'h00, 1'b0,1'b1,1'b0,1'b1,4'd9,8'h00, 1'b1,1'b0};

        // Reset: readies forced low even with requests present.
        rst0_n = 1'b0;
        flush_req = 1'b0;
        drive(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
        #3;
        chk("rst a_ready", a_ready, 1'b0);
        chk("rst b_ready", b_ready, 1'b0);
        chk("rst a_rvalid", a_rvalid, 1'b0);
        chk("rst b_rvalid", b_rvalid, 1'b0);
        chk("rst flush_busy", flush_busy, 1'b0);
        chk("rst flush_done", flush_done, 1'b0);
        chk("rst rdata", rdata, 8'h00);
        chk_idle_pins("rst");
        tick();
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        rst0_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle csb0", csb0, 1'b1);
            chk("idle ready", {a_ready, b_ready, a_rvalid, b_rvalid, flush_busy, flush_done}, 6'b0);
        end

        // Arbitration table, one row per cycle.
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(tbl[i].av, tbl[i].awe, tbl[i].aaddr, tbl[i].awd,
                  tbl[i].bv, tbl[i].bwe, tbl[i].baddr, tbl[i].bwd);
            #1;
            chk($sformatf("tbl%0d a_ready", i), a_ready, tbl[i].ar);
            chk($sformatf("tbl%0d b_ready", i), b_ready, tbl[i].br);
            chk($sformatf("tbl%0d csb0", i), csb0, tbl[i].csb);
            chk($sformatf("tbl%0d web0", i), web0, tbl[i].web);
            chk($sformatf("tbl%0d addr0", i), addr0, tbl[i].addr);
            chk($sformatf("tbl%0d din0", i), din0, tbl[i].din);
            chk($sformatf("tbl%0d a_rvalid", i), a_rvalid, tbl[i].arv);
            chk($sformatf("tbl%0d b_rvalid", i), b_rvalid, tbl[i].brv);
        end
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("tbl tail b_rvalid", b_rvalid, 1'b1);
        chk("tbl tail a_rvalid", a_rvalid, 1'b0);

        // Write then read the same address on port A.
        tick();
        drive(1'b1, 1'b1, 4'd3, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("wr a_ready", a_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("rd a_ready", a_ready, 1'b1);
        chk("rd a_rvalid early", a_rvalid, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("wr-rd a_rvalid", a_rvalid, 1'b1);
        chk("wr-rd rdata", rdata, 8'h3C);

        // Preload 5 and 9; leaves priority on A.
        tick();
        drive(1'b1, 1'b1, 4'd5, 8'h55, 1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd9, 8'h99);
        #1;
        chk("preload b_ready", b_ready, 1'b1);

        // Contention: both reading continuously.
        for (int k = 0; k < 6; k++) begin
            tick();
            drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
            #1;
            chk($sformatf("cont%0d a_ready", k), a_ready, (k % 2 == 0));
            chk($sformatf("cont%0d b_ready", k), b_ready, (k % 2 == 1));
            chk($sformatf("cont%0d addr0", k), addr0, (k % 2 == 0) ? 4'd5 : 4'd9);
            if (k > 0) begin
                chk($sformatf("cont%0d a_rvalid", k), a_rvalid, (k % 2 == 1));
                chk($sformatf("cont%0d b_rvalid", k), b_rvalid, (k % 2 == 0));
                chk($sformatf("cont%0d rdata", k), rdata, (k % 2 == 1) ? 8'h55 : 8'h99);
            end
        end

        // Flush with both ports requesting; flush_req held until flush_done.
        tick();
        flush_req = 1'b1;
        #1;
        chk("flush accept ready", {a_ready, b_ready}, 2'b00);
        chk("flush accept csb0", csb0, 1'b1);
        chk("flush accept b_rvalid", b_rvalid, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("flush%0d ready", k), {a_ready, b_ready}, 2'b00);
            chk($sformatf("flush%0d csb/web", k), {csb0, web0}, 2'b00);
            chk($sformatf("flush%0d addr0", k), addr0, k[3:0]);
            chk($sformatf("flush%0d din0", k), din0, 8'h5A);
            chk($sformatf("flush%0d busy", k), flush_busy, 1'b1);
            chk($sformatf("flush%0d done", k), flush_done, 1'b0);
        end
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            tick();
            if (flush_done) begin
                seen = 1'b1;
                flush_req = 1'b0;
                drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
                chk("flush_done latency", w, 0);
                chk("flush_done busy", flush_busy, 1'b0);
            end
        end
        chk("flush_done seen", seen, 1'b1);
        tick();
        chk("flush_done pulse", flush_done, 1'b0);
        chk("single sweep busy", flush_busy, 1'b0);
        for (int s = 0; s <= 16; s++) begin
            tick();
            if (s < 16) drive(1'b1, 1'b0, s[3:0], 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
            else        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
            #1;
            if (s > 0) begin
                chk($sformatf("readback%0d rvalid", s - 1), a_rvalid, 1'b1);
                chk($sformatf("readback%0d rdata", s - 1), rdata, 8'h5A);
            end
        end

        // Reset in the middle of a flush sweep.
        tick();
        flush_req = 1'b1;
        drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00);
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            tick();
            if (flush_busy && addr0 == 4'd7) seen = 1'b1;
        end
        chk("midflush reached 7", seen, 1'b1);
        rst0_n = 1'b0;
        flush_req = 1'b0;
        #1;
        chk("midrst busy", flush_busy, 1'b0);
        chk("midrst ready", {a_ready, b_ready}, 2'b00);
        chk("midrst rdata", rdata, 8'h00);
        chk_idle_pins("midrst");
        tick();
        rst0_n = 1'b1;
        #1;
        chk("post-rst a_ready", a_ready, 1'b1);
        chk("post-rst addr0", addr0, 4'd4);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("post-rst no done", flush_done, 1'b0);
            chk("post-rst busy", flush_busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
